// File: rtl/fb_swap_ctrl.sv
// Double-buffered frame memory between the renderer (writer) and the display (reader).
// Latency: rd_top/rd_btm lag rd_addr by one cycle; a write lands in the back bank on the accept edge.
// Backpressure: wr_ready is low while clearing and while a committed frame waits for frame_sync.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   rd_addr              display read address; rd_top/rd_btm return the front bank's pixels
//   frame_sync           display frame boundary pulse; the only point where banks swap
//   wr_valid/wr_ready    renderer write handshake into the back bank
//   wr_addr/wr_data      MSB of wr_addr picks half (0 top, 1 bottom), LSBs pick the entry
//   wr_last              final write of a frame; commits the back bank for the next swap
//   front_sel            bank currently displayed
//   init_done            power-on clear finished
//   repeat_cnt           saturating count of frame boundaries with no committed frame
module fb_swap_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12,
    parameter int DEPTH  = 1024,
    parameter int RPT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_top,
    output logic [DATA_W-1:0] rd_btm,
    input  logic              frame_sync,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              front_sel,
    output logic              init_done,
    output logic [RPT_W-1:0]  repeat_cnt
);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        FILL  = 2'd1,
        PEND  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] ptr;

    logic [DATA_W-1:0] mem0_top [DEPTH];
    logic [DATA_W-1:0] mem0_btm [DEPTH];
    logic [DATA_W-1:0] mem1_top [DEPTH];
    logic [DATA_W-1:0] mem1_btm [DEPTH];

    logic [ADDR_W-1:0] wr_idx;
    logic              wr_half;
    logic              wr_fire;
    logic              wr_in_range;

    assign wr_ready    = (state == FILL);
    assign wr_idx      = wr_addr[ADDR_W-1:0];
    assign wr_half     = wr_addr[ADDR_W];
    assign wr_fire     = wr_valid & wr_ready;
    // Out-of-range entries still complete the handshake; only the store is dropped.
    assign wr_in_range = (32'(wr_idx) < 32'(DEPTH));

    // Storage: the clear sweep zeroes all four arrays at ptr; otherwise the
    // renderer only ever touches the back bank (!front_sel), so reads of the
    // front bank can never collide with a write.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem0_top[ptr] <= '0;
            mem0_btm[ptr] <= '0;
            mem1_top[ptr] <= '0;
            mem1_btm[ptr] <= '0;
        end else if (wr_fire && wr_in_range) begin
            case ({front_sel, wr_half})
                2'b00:   mem1_top[wr_idx] <= wr_data;
                2'b01:   mem1_btm[wr_idx] <= wr_data;
                2'b10:   mem0_top[wr_idx] <= wr_data;
                default: mem0_btm[wr_idx] <= wr_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            ptr        <= '0;
            front_sel  <= 1'b0;
            init_done  <= 1'b0;
            repeat_cnt <= '0;
            rd_top     <= '0;
            rd_btm     <= '0;
        end else begin
            // Read path uses this cycle's front_sel, so a swap is visible for
            // addresses presented after the frame_sync cycle.
            if (state == CLEAR) begin
                rd_top <= '0;
                rd_btm <= '0;
            end else begin
                rd_top <= front_sel ? mem1_top[rd_addr] : mem0_top[rd_addr];
                rd_btm <= front_sel ? mem1_btm[rd_addr] : mem0_btm[rd_addr];
            end

            case (state)
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST_PTR) begin
                        state     <= FILL;
                        init_done <= 1'b1;
                    end
                end
                FILL: begin
                    // A boundary with no committed frame repeats the old one.
                    // This also applies when the commit lands on the same edge.
                    if (frame_sync && (repeat_cnt != '1)) begin
                        repeat_cnt <= repeat_cnt + 1'b1;
                    end
                    if (wr_fire && wr_last) begin
                        state <= PEND;
                    end
                end
                PEND: begin
                    if (frame_sync) begin
                        front_sel <= ~front_sel;
                        state     <= FILL;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_swap_ctrl.sv
module tb_fb_swap_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 12;
    localparam int DEPTH  = 1024;
    localparam int RPT_W  = 8;
    localparam int RPT_MAX = (1 << RPT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_top;
    logic [DATA_W-1:0] rd_btm;
    logic              frame_sync;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W:0]   wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              front_sel;
    logic              init_done;
    logic [RPT_W-1:0]  repeat_cnt;

    int checks   = 0;
    int failures = 0;

    fb_swap_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .RPT_W (RPT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_top    (rd_top),
        .rd_btm    (rd_btm),
        .frame_sync(frame_sync),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_last   (wr_last),
        .front_sel (front_sel),
        .init_done (init_done),
        .repeat_cnt(repeat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Frame-level view: a cycle count since reset decides whether the clear is
    // still running; a "committed frame waiting" flag decides acceptance.
    int unsigned       since_rst;
    bit                m_front;
    bit                m_pending;
    int                m_rep;
    logic [DATA_W-1:0] m_mem [2][2][DEPTH];
    logic [DATA_W-1:0] m_top;
    logic [DATA_W-1:0] m_btm;
    bit                started = 1'b0;
    bit                m_clearing;
    bit                m_rdy;
    bit                m_commit;

    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            since_rst = 0;
            m_front   = 1'b0;
            m_pending = 1'b0;
            m_rep     = 0;
            m_top     = '0;
            m_btm     = '0;
            for (int b = 0; b < 2; b++)
                for (int h = 0; h < 2; h++)
                    for (int e = 0; e < DEPTH; e++)
                        m_mem[b][h][e] = '0;
        end else begin
            m_clearing = (since_rst < DEPTH);
            m_rdy      = !m_clearing && !m_pending;
            m_commit   = 1'b0;
            if (m_clearing) begin
                m_top = '0;
                m_btm = '0;
            end else begin
                m_top = m_mem[m_front][0][rd_addr];
                m_btm = m_mem[m_front][1][rd_addr];
            end
            if (m_rdy && wr_valid) begin
                if (int'(wr_addr[ADDR_W-1:0]) < DEPTH)
                    m_mem[!m_front][wr_addr[ADDR_W]][wr_addr[ADDR_W-1:0]] = wr_data;
                m_commit = wr_last;
            end
            if (!m_clearing && frame_sync) begin
                if (m_pending) begin
                    m_front   = !m_front;
                    m_pending = 1'b0;
                end else if (m_rep < RPT_MAX) begin
                    m_rep++;
                end
            end
            if (m_commit) m_pending = 1'b1;
            if (since_rst < 32'hFFFF_0000) since_rst++;
        end
    end

    // Single compare process: every cycle once the clock has started.
    always @(negedge clk) begin
        if (started) begin
            chk("cmp_rd_top",     32'(rd_top),     32'(m_top));
            chk("cmp_rd_btm",     32'(rd_btm),     32'(m_btm));
            chk("cmp_front_sel",  32'(front_sel),  32'(m_front));
            chk("cmp_init_done",  32'(init_done),  32'(since_rst >= DEPTH));
            chk("cmp_wr_ready",   32'(wr_ready),   32'((since_rst >= DEPTH) && !m_pending));
            chk("cmp_repeat_cnt", 32'(repeat_cnt), 32'(m_rep));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic half, input int idx, input logic [DATA_W-1:0] d, input logic last);
        wr_valid = 1'b1;
        wr_addr  = {half, ADDR_W'(idx)};
        wr_data  = d;
        wr_last  = last;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic pulse_sync();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_front"}, 32'(front_sel),  32'd0);
        chk({tag, "_init"},  32'(init_done),  32'd0);
        chk({tag, "_ready"}, 32'(wr_ready),   32'd0);
        chk({tag, "_rep"},   32'(repeat_cnt), 32'd0);
        chk({tag, "_top"},   32'(rd_top),     32'd0);
        chk({tag, "_btm"},   32'(rd_btm),     32'd0);
    endtask

    // Sweep rd_addr across the clear; init_done must rise exactly after DEPTH cycles.
    task automatic clear_sweep(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = ADDR_W'(i);
            if (i == DEPTH - 1) chk({tag, "_init_before"}, 32'(init_done), 32'd0);
            tick();
        end
        chk({tag, "_init_after"},  32'(init_done), 32'd1);
        chk({tag, "_ready_after"}, 32'(wr_ready),  32'd1);
    endtask

    task automatic read_sweep();
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = ADDR_W'(i);
            tick();
        end
    endtask

    initial begin
        rst        = 1'b1;
        rd_addr    = '0;
        frame_sync = 1'b0;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        wr_last    = 1'b0;
        tick(); tick(); tick();
        chk_reset_vals("rst0");

        // 1: power-on clear, then front bank reads all zero
        rst = 1'b0;
        clear_sweep("clr0");
        chk("clr0_front", 32'(front_sel), 32'd0);
        read_sweep();
        rd_addr = 10'd5;
        tick(); tick();
        chk("clr0_rd5_top", 32'(rd_top), 32'h000);
        chk("clr0_rd5_btm", 32'(rd_btm), 32'h000);

        // 2: full frame into back bank, commit, swap
        for (int i = 0; i < DEPTH; i++) begin
            wr(1'b0, i, DATA_W'(i), 1'b0);
            wr(1'b1, i, DATA_W'(~i) & 12'hFFF, (i == DEPTH - 1));
        end
        tick(); tick();
        chk("pend_ready", 32'(wr_ready),  32'd0);
        chk("pend_front", 32'(front_sel), 32'd0);
        pulse_sync();
        chk("swap_front", 32'(front_sel), 32'd1);
        chk("swap_ready", 32'(wr_ready),  32'd1);
        rd_addr = 10'd5;
        tick();
        chk("swap_rd5_top", 32'(rd_top), 32'h005);
        chk("swap_rd5_btm", 32'(rd_btm), 32'hFFA);
        rd_addr = 10'd1023;
        tick();
        chk("swap_rd1023_top", 32'(rd_top), 32'h3FF);
        chk("swap_rd1023_btm", 32'(rd_btm), 32'hC00);

        // 3: commit coincident with frame_sync -> pend, repeat, no swap
        wr_valid   = 1'b1;
        wr_addr    = {1'b0, 10'd0};
        wr_data    = 12'h111;
        wr_last    = 1'b1;
        frame_sync = 1'b1;
        tick();
        wr_valid   = 1'b0;
        wr_last    = 1'b0;
        frame_sync = 1'b0;
        chk("coinc_rep",   32'(repeat_cnt), 32'd1);
        chk("coinc_front", 32'(front_sel),  32'd1);
        chk("coinc_ready", 32'(wr_ready),   32'd0);

        // write attempts while pending must be ignored
        wr_valid = 1'b1;
        wr_addr  = {1'b0, 10'd0};
        wr_data  = 12'hABC;
        for (int k = 0; k < 3; k++) tick();
        chk("pend_hold_ready", 32'(wr_ready), 32'd0);
        wr_valid = 1'b0;
        pulse_sync();
        chk("swapback_front", 32'(front_sel),  32'd0);
        chk("swapback_rep",   32'(repeat_cnt), 32'd1);
        rd_addr = 10'd0;
        tick();
        chk("swapback_rd0_top", 32'(rd_top), 32'h111);

        // 4: 300 uncommitted frame boundaries -> saturating repeat count
        for (int p = 1; p <= 300; p++) begin
            pulse_sync();
            tick();
            if (p == 100) chk("rep_100", 32'(repeat_cnt), 32'd101);
        end
        chk("rep_sat",   32'(repeat_cnt), 32'd255);
        chk("rep_front", 32'(front_sel),  32'd0);

        // 5: reset mid-fill restarts the clear and zeroes both banks
        for (int i = 0; i < 500; i++) wr(1'b0, i, 12'h5A5, 1'b0);
        wr_valid = 1'b1;
        wr_addr  = {1'b0, 10'd500};
        wr_data  = 12'h5A5;
        rst      = 1'b1;
        tick();
        chk_reset_vals("rst1");
        tick();
        wr_valid = 1'b0;
        rst      = 1'b0;
        clear_sweep("clr1");
        read_sweep();
        rd_addr = 10'd0;
        tick();
        chk("clr1_bank0_rd0", 32'(rd_top), 32'h000);
        wr(1'b0, DEPTH - 1, 12'h007, 1'b1);
        pulse_sync();
        chk("clr1_front", 32'(front_sel), 32'd1);
        read_sweep();
        rd_addr = 10'd0;
        tick();
        chk("clr1_bank1_rd0", 32'(rd_top), 32'h000);
        rd_addr = 10'd1023;
        tick();
        chk("clr1_bank1_rd1023", 32'(rd_top), 32'h007);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fb_swap_ctrl.md
Name: fb_swap_ctrl

Overview:
Double-buffered frame-memory controller between the lava-lamp renderer (writer) and dspl_ctrl (reader). It holds two banks, each split into top and bottom halves of DEPTH x DATA_W. It serves dspl_ctrl's r_addr from the front bank and accepts renderer writes into the back bank through a valid/ready handshake. It swaps banks only on a frame boundary, so the panel never shows a partially rendered frame.

Parameters:
ADDR_W, 10, address width of one half-bank (matches dspl_ctrl r_addr)
DATA_W, 12, pixel width, 4:4:4 RGB (matches dspl_ctrl din_top/din_btm)
DEPTH, 1024, entries per half-bank (16 rows x 64 columns)
RPT_W, 8, width of the saturating repeat counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rd_addr  in  ADDR_W  display read address (from dspl_ctrl r_addr)
rd_top  out  DATA_W  front-bank top-half pixel (to dspl_ctrl din_top)
rd_btm  out  DATA_W  front-bank bottom-half pixel (to dspl_ctrl din_btm)
frame_sync  in  1  single-cycle pulse marking the display frame boundary
wr_valid  in  1  renderer write request
wr_ready  out  1  controller accepts a write this cycle
wr_addr  in  ADDR_W+1  MSB selects half (0 = top, 1 = bottom); LSBs are the entry index
wr_data  in  DATA_W  pixel to write
wr_last  in  1  qualifies the final write of a frame (commit)
front_sel  out  1  bank currently displayed
init_done  out  1  high once power-on clear is complete
repeat_cnt  out  RPT_W  frame_sync events with no committed frame (saturating)

Behaviour:
- Storage: four arrays, bank{0,1} x half{top,btm}, each DEPTH x DATA_W. Synchronous read, synchronous write.
- Reset values: state=CLEAR, clear pointer=0, front_sel=0, init_done=0, wr_ready=0, repeat_cnt=0, rd_top=0, rd_btm=0.
- Reset is honoured from any state at any time. It restarts the clear, and memory contents are rewritten to zero.
- State CLEAR:
  - Writes 0 to address ptr in all four arrays each cycle; ptr increments.
  - After the write at ptr=DEPTH-1 (DEPTH cycles after reset deasserts), next state is FILL and init_done goes 1 and stays 1 until the next reset.
  - wr_ready=0 throughout. frame_sync is ignored and does not count.
  - rd_top/rd_btm output 0.
- State FILL:
  - wr_ready=1. A write occurs when wr_valid & wr_ready, into bank !front_sel, half wr_addr[ADDR_W], entry wr_addr[ADDR_W-1:0].
  - An accepted write with wr_last=1 moves the state to PEND.
  - A frame_sync in FILL increments repeat_cnt, saturating at 2^RPT_W-1; front_sel is unchanged.
- State PEND:
  - wr_ready=0; no writes occur.
  - On frame_sync: front_sel toggles, state returns to FILL, repeat_cnt is unchanged.
- Simultaneous accepted wr_last and frame_sync in FILL: the write completes, state goes to PEND, repeat_cnt increments, no swap. The swap waits for the next frame_sync.
- wr_ready is a combinational function of state only. It does not depend on wr_valid.
- Read path:
  - 1-cycle latency: rd_top/rd_btm in cycle n+1 = front bank[rd_addr] sampled in cycle n.
  - The bank is selected by the front_sel value in cycle n. A swap takes effect for addresses presented the cycle after the frame_sync cycle.
- No read/write collision is possible: reads always target the front bank, writes always the back bank.
- wr_addr entry index >= DEPTH (only when DEPTH < 2^ADDR_W): the write is dropped, but the handshake still completes and wr_last still commits.
- Frame semantics: the renderer must write every entry of the back bank each frame. The controller does not copy front to back.

Test Plan:
- Reset, rd_addr sweep 0..1023 -> wr_ready=0 and init_done=0 for 1024 cycles after rst drops, then init_done=1, wr_ready=1; all reads return 0x000 (both halves), front_sel=0.
- Write top[i]=i, btm[i]=~i&0xFFF for i=0..1023, last write with wr_last=1, then frame_sync -> wr_ready=0 until frame_sync; front_sel=1 the cycle after; read addr 5 returns top=0x005, btm=0xFFA one cycle later.
- 300 frame_sync pulses with no commit after init -> repeat_cnt increments per pulse, holds at 255; front_sel stays 0.
- Accepted wr_last in the same cycle as frame_sync -> state PEND, repeat_cnt +1, front_sel unchanged; next frame_sync -> front_sel toggles, repeat_cnt unchanged.
- wr_valid held high in PEND with data 0xABC at addr 0 -> no write (back bank addr 0 keeps old value after the swap-back cycle); wr_ready=0.
- rst asserted mid-FILL after 500 writes -> all outputs return to reset values; full 1024-cycle clear repeats; both banks read 0 afterwards.
